frac_tick_generator: RTL
========================

// Module: frac_tick_generator
// PURPOSE
//  Multi-channel fractional (phase-accumulator) tick generator for the desk clock.
//  Derives NUM_CH independent low-rate enables (1 Hz timekeeping, fast-set, blink, debounce)
//  from the single system clock.
//  Per-channel increments are runtime-programmable through a write handshake and take
//  effect glitch-free at that channel's next wrap.
//  A sync-clear aligns all channel phases.
// PARAMETERS
//  NUM_CH       4                      number of channels (1..16)
//  ACC_W        32                     accumulator/increment width, bits (8..32)
//  DEFAULT_INC  {NUM_CH{32'd86}}       packed NUM_CH*ACC_W reset increments; ch c at [c*ACC_W +: ACC_W]
//  CH_W         $clog2(NUM_CH) (min 1) channel-select width (derived, not overridden)
// PORTS
//  i_sysclk     in   1            system clock, all logic on rising edge
//  i_reset_n    in   1            asynchronous active-low reset
//  i_en         in   1            global advance enable
//  i_sync_clr   in   1            zero all accumulators (phase align)
//  i_inc_wr     in   1            increment write request
//  i_ch_sel     in   CH_W         channel addressed by the write
//  i_inc        in   ACC_W        new increment value
//  o_inc_ready  out  1            write accepted this cycle if high with i_inc_wr
//  o_div        out  NUM_CH       per-channel accumulator MSB (~50% duty divided clock)
//  o_tick       out  NUM_CH       per-channel 1-cycle pulse on accumulator wrap
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - acc[c]=0, inc[c]=DEFAULT_INC slice, pend[c]=0.
//   - o_tick=0, o_div=0, o_inc_ready=1.
//  Accumulator, per channel, when i_en=1:
//   - {carry,acc_next} = acc + inc, ACC_W+1 bits; acc <= acc_next (mod 2^ACC_W).
//   - o_tick[c] <= carry (registered). The tick is high in the same cycle acc shows the wrapped value.
//   - Rate = f_sysclk * inc / 2^ACC_W.
//   - inc=0 halts the channel: no ticks, o_div holds.
//  i_en=0:
//   - acc and pend hold; o_tick <= 0.
//  o_div[c] = acc[c][ACC_W-1], combinational from the register.
//  Write handshake:
//   - o_inc_ready = !pend[i_ch_sel] (combinational).
//   - Accept = i_inc_wr & o_inc_ready: shadow[ch] <= i_inc, pend[ch] <= 1.
//   - i_inc_wr while not ready is ignored. The master holds the request until ready.
//   - i_ch_sel >= NUM_CH: the write is accepted and discarded (no state change).
//   - Pending apply: on a cycle where ch c carries (i_en=1), the wrap uses the OLD inc.
//     Then inc[c] <= shadow[c] and pend[c] <= 0.
//   - Accept and carry on the same ch in the same cycle: the new value stays pending until the following wrap.
//   - Pending apply when the current inc=0: the channel never wraps, so the shadow applies on the next cycle
//     regardless of i_en.
//  i_sync_clr (priority over i_en):
//   - all acc <= 0 and o_tick <= 0.
//   - every pending shadow applies immediately; pend <= 0.
//   - A write accepted in the same cycle still applies (ready is evaluated before the clear).
//  Reset mid-operation:
//   - all state returns to reset values, including pending writes.
//   - The next tick occurs 2^ACC_W/DEFAULT_INC cycles after release.
// TESTING (NUM_CH=2, ACC_W=8, DEFAULT_INC={8'd32,8'd64})
//  1. Reset release, i_en=1 -> ch0 o_tick every 4 cycles, first on cycle 4; ch1 every 8.
//     o_div[0] toggles every 2 cycles.
//  2. i_en low for 5 cycles mid-period -> no ticks; phase resumes exactly, period extended by 5.
//  3. Write ch0 inc=128 -> ready drops for ch0 and stays high for ch1.
//     The next ch0 wrap is still at the 64 spacing; after it, ticks come every 2 cycles; ready returns high.
//  4. Write on ch0 in the same cycle as a ch0 carry -> that tick occurs.
//     The new inc applies only at the following wrap.
//  5. i_sync_clr with ch1 pending inc=16 -> acc=0, no tick that cycle.
//     ch1 then ticks every 16 cycles; ch0 and ch1 are phase aligned.
//  6. Assert i_reset_n low asynchronously mid-period, with a pending write ->
//     outputs go 0 immediately; after release the pending value is lost and the defaults resume.

Source files
------------

// File: rtl/frac_tick_if.sv
// Increment-write handshake bundle for frac_tick_generator.
// The master drives a write request, channel select and value; the slave
// answers with a combinational ready.
interface frac_tick_if #(
  parameter int ACC_W = 32,
  parameter int CH_W  = 2
);
  logic             i_inc_wr;
  logic [CH_W-1:0]  i_ch_sel;
  logic [ACC_W-1:0] i_inc;
  logic             o_inc_ready;

  modport master (
    output i_inc_wr,
    output i_ch_sel,
    output i_inc,
    input  o_inc_ready
  );

  modport slave (
    input  i_inc_wr,
    input  i_ch_sel,
    input  i_inc,
    output o_inc_ready
  );
endinterface

// File: rtl/frac_tick_generator.sv
// Multi-channel phase-accumulator tick generator.
// Each channel adds its increment every enabled cycle; the carry out of the
// accumulator is registered as a one-cycle tick and the accumulator MSB is a
// roughly 50% duty divided clock. New increments are written into a per-channel
// shadow and swapped in at that channel's next wrap so the running period is
// never cut short. A sync-clear zeroes every phase and applies all shadows.
module frac_tick_generator #(
  parameter int                        NUM_CH      = 4,
  parameter int                        ACC_W       = 32,
  parameter logic [NUM_CH*ACC_W-1:0]   DEFAULT_INC = {NUM_CH{32'd86}}
) (
  input  logic              i_sysclk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic              i_sync_clr,
  frac_tick_if.slave        inc_bus,
  output logic [NUM_CH-1:0] o_div,
  output logic [NUM_CH-1:0] o_tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] pend_vec;
  logic              ready;
  logic              accept;

  // Ready is low only while the addressed channel still holds an unapplied
  // shadow; a select beyond the last channel matches nothing, so it is always
  // accepted and simply dropped.
  always_comb begin
    ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (inc_bus.i_ch_sel == CH_W'(c) && pend_vec[c]) begin
        ready = 1'b0;
      end
    end
  end

  assign inc_bus.o_inc_ready = ready;
  assign accept              = inc_bus.i_inc_wr & ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] inc_reg;
      logic [ACC_W-1:0] shadow_reg;
      logic             pend_reg;
      logic             tick_reg;
      logic [ACC_W:0]   sum;
      logic             carry;
      logic             hit;

      assign sum   = {1'b0, acc_reg} + {1'b0, inc_reg};
      assign carry = sum[ACC_W];
      assign hit   = accept && (inc_bus.i_ch_sel == CH_W'(gi));

      // Accumulate, register the wrap as a tick, and swap in a pending
      // increment after the wrap that still used the old one. A zero
      // increment never wraps, so its shadow is taken straight away.
      always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          acc_reg    <= '0;
          inc_reg    <= DEFAULT_INC[gi*ACC_W +: ACC_W];
          shadow_reg <= '0;
          pend_reg   <= 1'b0;
          tick_reg   <= 1'b0;
        end else if (i_sync_clr) begin
          acc_reg  <= '0;
          tick_reg <= 1'b0;
          pend_reg <= 1'b0;
          if (hit) begin
            inc_reg    <= inc_bus.i_inc;
            shadow_reg <= inc_bus.i_inc;
          end else if (pend_reg) begin
            inc_reg <= shadow_reg;
          end
        end else begin
          if (i_en) begin
            acc_reg  <= sum[ACC_W-1:0];
            tick_reg <= carry;
          end else begin
            tick_reg <= 1'b0;
          end
          if (pend_reg && ((i_en && carry) || (inc_reg == '0))) begin
            inc_reg  <= shadow_reg;
            pend_reg <= 1'b0;
          end
          // hit implies pend_reg was clear, so it never collides with the apply
          if (hit) begin
            shadow_reg <= inc_bus.i_inc;
            pend_reg   <= 1'b1;
          end
        end
      end

      assign pend_vec[gi] = pend_reg;
      assign o_tick[gi]   = tick_reg;
      assign o_div[gi]    = acc_reg[ACC_W-1];
    end
  endgenerate

endmodule
